// File: rtl/program_loader.sv
// program_loader: packs a big-endian byte stream into 28-bit instructions, writes them to
// instruction RAM at consecutive addresses and holds the core in reset until the load completes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned INSTR_W   = 28,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               iStart,
  input  logic [ADDR_W-1:0]  iWordCount,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  output logic               oByteReady,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oCpuReset,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);

  // Holds op nibble plus the two following bytes while the last byte of a word arrives.
  localparam int unsigned SHIFT_W = 20;
  localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
`ifdef LOADER_CHECKSUM_EN
    , CHECK = 3'd5
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FINISH_STATE = CHECK;
`else
  localparam state_t FINISH_STATE = DONE;
`endif

  state_t               state, stateNext;
  logic [ADDR_W-1:0]    wordCount, wordCountNext;
  logic [ADDR_W-1:0]    wordIdx, wordIdxNext;
  logic [1:0]           byteCnt, byteCntNext;
  logic [SHIFT_W-1:0]   shiftReg, shiftNext;
  logic                 writeEnableNext;
  logic [ADDR_W-1:0]    writeAddressNext;
  logic [INSTR_W-1:0]   instructionNext;
  logic                 readyNext;
  logic                 busyNext;
  logic                 doneNext;
  logic                 errorNext;
  logic                 cpuResetNext;
  logic                 byteFire;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           checksum, checksumNext;
`endif

  assign byteFire = iByteValid && oByteReady;

  // Next-state, datapath and registered-output values.
  always_comb begin
    stateNext        = state;
    wordCountNext    = wordCount;
    wordIdxNext      = wordIdx;
    byteCntNext      = byteCnt;
    shiftNext        = shiftReg;
    writeEnableNext  = 1'b0;
    writeAddressNext = oWriteAddress;
    instructionNext  = oInstruction;
`ifdef LOADER_CHECKSUM_EN
    checksumNext     = checksum;
`endif

    case (state)
      IDLE, DONE, ERROR: begin
        if (iStart) begin
          wordCountNext = iWordCount;
          wordIdxNext   = '0;
          byteCntNext   = '0;
`ifdef LOADER_CHECKSUM_EN
          checksumNext  = '0;
`endif
          if (iWordCount > MAX_N) begin
            stateNext = ERROR;
          end else if (iWordCount == '0) begin
            stateNext = FINISH_STATE;
          end else begin
            stateNext = RECV;
          end
        end
      end

      RECV: begin
        if (byteFire) begin
          byteCntNext = byteCnt + 2'd1;
          shiftNext   = {shiftReg[SHIFT_W-9:0], iByte};
`ifdef LOADER_CHECKSUM_EN
          checksumNext = checksum ^ iByte;
`endif
          // Fourth byte completes the word; byte0[7:4] has already shifted out.
          if (byteCnt == 2'd3) begin
            stateNext        = WRITE;
            writeEnableNext  = 1'b1;
            writeAddressNext = wordIdx;
            instructionNext  = INSTR_W'({shiftReg, iByte});
          end
        end
      end

      WRITE: begin
        wordIdxNext = wordIdx + ADDR_W'(1);
        if (wordIdx == wordCount - ADDR_W'(1)) begin
          stateNext = FINISH_STATE;
        end else begin
          stateNext = RECV;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (byteFire) begin
          stateNext = (iByte == checksum) ? DONE : ERROR;
        end
      end
`endif

      default: stateNext = IDLE;
    endcase

    readyNext    = (stateNext == RECV);
    busyNext     = (stateNext == RECV) || (stateNext == WRITE);
`ifdef LOADER_CHECKSUM_EN
    readyNext    = readyNext || (stateNext == CHECK);
    busyNext     = busyNext || (stateNext == CHECK);
`endif
    doneNext     = (stateNext == DONE);
    errorNext    = (stateNext == ERROR);
    cpuResetNext = (stateNext != DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      wordCount     <= '0;
      wordIdx       <= '0;
      byteCnt       <= '0;
      shiftReg      <= '0;
      oByteReady    <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oInstruction  <= '0;
      oCpuReset     <= 1'b1;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      state         <= stateNext;
      wordCount     <= wordCountNext;
      wordIdx       <= wordIdxNext;
      byteCnt       <= byteCntNext;
      shiftReg      <= shiftNext;
      oByteReady    <= readyNext;
      oWriteEnable  <= writeEnableNext;
      oWriteAddress <= writeAddressNext;
      oInstruction  <= instructionNext;
      oCpuReset     <= cpuResetNext;
      oBusy         <= busyNext;
      oDone         <= doneNext;
      oError        <= errorNext;
`ifdef LOADER_CHECKSUM_EN
      checksum      <= checksumNext;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized loads of program_loader checked against a
// word-level model of the expected RAM writes; follows LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned INSTR_W   = 28;
  localparam int          MAX_WORDS = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic               Clock;
  logic               Reset_n;
  logic               iStart;
  logic [ADDR_W-1:0]  iWordCount;
  logic [7:0]         iByte;
  logic               iByteValid;
  logic               oByteReady;
  logic               oWriteEnable;
  logic [ADDR_W-1:0]  oWriteAddress;
  logic [INSTR_W-1:0] oInstruction;
  logic               oCpuReset;
  logic               oBusy;
  logic               oDone;
  logic               oError;

  int nAsserts    = 0;
  int nFail       = 0;
  int cyc         = 0;
  int lastFireCyc = -100;
  int nFired      = 0;

  logic [ADDR_W-1:0]  wAddr[$];
  logic [INSTR_W-1:0] wData[$];
  logic [7:0]         txBytes[$];

  program_loader dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .iStart       (iStart),
    .iWordCount   (iWordCount),
    .iByte        (iByte),
    .iByteValid   (iByteValid),
    .oByteReady   (oByteReady),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oInstruction (oInstruction),
    .oCpuReset    (oCpuReset),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oError       (oError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected instruction: low nibble of byte0 is the opcode, then three full bytes.
  function automatic logic [31:0] expWord(input int w);
    int unsigned b0, b1, b2, b3;
    b0 = 32'(txBytes[4*w]);
    b1 = 32'(txBytes[4*w+1]);
    b2 = 32'(txBytes[4*w+2]);
    b3 = 32'(txBytes[4*w+3]);
    return (b0 % 16) * 16777216 + b1 * 65536 + b2 * 256 + b3;
  endfunction

  // Observe writes and byte transfers away from the rising edge.
  always @(negedge Clock) begin
    cyc++;
    if (oWriteEnable) begin
      wAddr.push_back(oWriteAddress);
      wData.push_back(oInstruction);
      check("write_latency", 32'(cyc - lastFireCyc), 32'd1);
      check("ready_in_write", 32'(oByteReady), 32'd0);
    end
    if (iByteValid && oByteReady && Reset_n) begin
      lastFireCyc = cyc;
      nFired++;
    end
  end

  task automatic checkResetOutputs(input string p);
    check({p, "_ready"},    32'(oByteReady),    32'd0);
    check({p, "_we"},       32'(oWriteEnable),  32'd0);
    check({p, "_addr"},     32'(oWriteAddress), 32'd0);
    check({p, "_instr"},    32'(oInstruction),  32'd0);
    check({p, "_cpureset"}, 32'(oCpuReset),     32'd1);
    check({p, "_busy"},     32'(oBusy),         32'd0);
    check({p, "_done"},     32'(oDone),         32'd0);
    check({p, "_error"},    32'(oError),        32'd0);
  endtask

  task automatic fillRandom(input int n);
    txBytes.delete();
    repeat (4 * n) txBytes.push_back(8'($urandom));
  endtask

  // gap: 0 = valid every cycle, 1 = valid toggles 1/0, 2 = random idle cycles.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int idle;
    bit taken;
    idle = 0;
    if (gap == 1) idle = 1;
    else if (gap == 2 && $urandom_range(0, 2) == 0) idle = int'($urandom_range(1, 2));
    repeat (idle) begin
      iByteValid = 1'b0;
      iByte      = 8'($urandom);
      @(posedge Clock); #1;
    end
    iByte      = b;
    iByteValid = 1'b1;
    taken      = 1'b0;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge Clock);
      taken = oByteReady;
      @(posedge Clock); #1;
    end
    iByteValid = 1'b0;
    if (!taken) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic startLoad(input int n);
    iWordCount = 16'(n);
    iStart     = 1'b1;
    @(posedge Clock); #1;
    iStart     = 1'b0;
    iWordCount = 16'($urandom);
    if (n >= 1 && n <= MAX_WORDS) begin
      check("start_busy",     32'(oBusy),      32'd1);
      check("start_ready",    32'(oByteReady), 32'd1);
      check("start_done",     32'(oDone),      32'd0);
      check("start_cpureset", 32'(oCpuReset),  32'd1);
    end
  endtask

  task automatic waitEnd();
    bit ended;
    ended = 1'b0;
    for (int k = 0; k < 40 && !ended; k++) begin
      @(negedge Clock);
      ended = oDone || oError;
    end
    if (!ended) check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendChecksum(input int n, input int gap, input bit badSum);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 4 * n; i++) sum = sum ^ txBytes[i];
    sendByte(badSum ? (sum ^ 8'h01) : sum, gap);
  endtask

  task automatic checkResult(input int n, input bit expDone, input int fired0);
    int expW;
    expW = (n <= MAX_WORDS) ? n : 0;
    check("end_done",     32'(oDone),      32'(expDone));
    check("end_error",    32'(oError),     32'(!expDone));
    check("end_cpureset", 32'(oCpuReset),  32'(!expDone));
    check("end_busy",     32'(oBusy),      32'd0);
    check("end_ready",    32'(oByteReady), 32'd0);
    check("write_count",  32'(wAddr.size()), 32'(expW));
    check("bytes_taken",  32'(nFired - fired0),
          (n <= MAX_WORDS) ? 32'(4 * n + int'(CSUM_EN)) : 32'd0);
    for (int i = 0; i < expW && i < wAddr.size(); i++) begin
      check($sformatf("waddr[%0d]", i), 32'(wAddr[i]), 32'(i));
      check($sformatf("wdata[%0d]", i), 32'(wData[i]), expWord(i));
    end
    if (expW > 0) check("addr_hold", 32'(oWriteAddress), 32'(expW - 1));
  endtask

  task automatic runLoad(input int n, input int gap, input bit badSum);
    int fired0;
    bit expDone;
    wAddr.delete();
    wData.delete();
    fired0 = nFired;
    startLoad(n);
    if (n <= MAX_WORDS) begin
      for (int i = 0; i < 4 * n; i++) sendByte(txBytes[i], gap);
      if (CSUM_EN) sendChecksum(n, gap, badSum);
    end
    waitEnd();
    expDone = (n <= MAX_WORDS) && !(CSUM_EN && badSum);
    checkResult(n, expDone, fired0);
  endtask

  initial begin
    int fired0;
    Reset_n    = 1'b0;
    iStart     = 1'b0;
    iWordCount = '0;
    iByte      = '0;
    iByteValid = 1'b0;

    // Reset values, then idle after release.
    repeat (2) @(negedge Clock);
    checkResetOutputs("rst");
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    repeat (3) @(negedge Clock);
    checkResetOutputs("idle");
    check("idle_no_writes", 32'(wAddr.size()), 32'd0);

    // Two-word load, continuous and with valid toggling.
    txBytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    runLoad(2, 0, 1'b0);
    runLoad(2, 1, 1'b0);

    // Boundaries: empty program, oversize program, high nibble of byte0 dropped.
    runLoad(0, 0, 1'b0);
    runLoad(257, 0, 1'b0);
    txBytes = '{8'hF5, 8'h12, 8'h34, 8'h56};
    runLoad(1, 0, 1'b0);
    runLoad(65535, 0, 1'b0);

    // iStart during a load is ignored.
    txBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    wAddr.delete();
    wData.delete();
    fired0 = nFired;
    startLoad(2);
    for (int i = 0; i < 3; i++) sendByte(txBytes[i], 0);
    iWordCount = 16'd1;
    iStart     = 1'b1;
    @(posedge Clock); #1;
    iStart     = 1'b0;
    for (int i = 3; i < 8; i++) sendByte(txBytes[i], 0);
    if (CSUM_EN) sendChecksum(2, 0, 1'b0);
    waitEnd();
    checkResult(2, 1'b1, fired0);

    // Reset mid-load abandons it; a fresh load starts again at address 0.
    txBytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    wAddr.delete();
    wData.delete();
    startLoad(2);
    for (int i = 0; i < 6; i++) sendByte(txBytes[i], 0);
    Reset_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    repeat (4) @(negedge Clock);
    check("midrst_writes", 32'(wAddr.size()), 32'd1);
    check("midrst_busy",   32'(oBusy),        32'd0);
    if (wAddr.size() > 0) check("midrst_wdata0", 32'(wData[0]), 32'h0102_0304);
    fillRandom(1);
    runLoad(1, 0, 1'b0);

    // Checksum trailer good/bad, then restart from ERROR.
    txBytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    runLoad(1, 0, 1'b0);
    runLoad(1, 0, 1'b1);
    runLoad(1, 2, 1'b0);

    // Randomized loads with random gaps.
    for (int t = 0; t < 10; t++) begin
      int n;
      n = int'($urandom_range(0, 6));
      fillRandom(n);
      runLoad(n, 2, 1'($urandom_range(0, 1)));
    end

    // Largest accepted program.
    fillRandom(MAX_WORDS);
    runLoad(MAX_WORDS, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
